// File: rtl/exec_muldiv_seq.sv
// Iterative unsigned multiply/divide sequencer beside the Exec-stage ALU; stalls the pipe while iterating.
// Define MULDIV_DIV_EN to build the restoring divider; otherwise DIVU/REMU report illegal_op.
module exec_muldiv_seq #(
    parameter int XLEN      = 32,
    parameter bit FAST_ZERO = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] operand_A,
    input  logic [XLEN-1:0] operand_B,
    input  logic            flush,
    output logic            busy,
    output logic            stall_pipe,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            illegal_op
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t              r_state;
    logic                r_busy;
    logic                r_done;
    logic                r_illegal;
    logic [XLEN-1:0]     r_result;
    logic [XLEN-1:0]     r_operand;
    logic [2*XLEN-1:0]   r_acc;
    logic [CW-1:0]       r_count;
    logic                r_opHigh;
`ifdef MULDIV_DIV_EN
    logic                r_isDiv;
`endif

    logic [XLEN:0]       w_mulSum;
    logic [2*XLEN-1:0]   w_mulNext;
    logic [2*XLEN-1:0]   w_accNext;
    logic [XLEN-1:0]     w_calcResult;
    logic                w_lastIter;
    logic                w_accept;
    logic                w_early;
    logic                w_earlyIllegal;
    logic [XLEN-1:0]     w_earlyResult;

    // Multiply: {hi,lo} accumulator, multiplier starts in lo and is consumed LSB-first.
    assign w_mulSum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_operand} : '0);
    assign w_mulNext = {w_mulSum, r_acc[XLEN-1:1]};

`ifdef MULDIV_DIV_EN
    logic [XLEN:0]       w_divShift;
    logic                w_divGe;
    logic [XLEN-1:0]     w_divRem;
    logic [2*XLEN-1:0]   w_divNext;

    // Divide: {rem,quo} accumulator; the shifted remainder needs XLEN+1 bits for the trial compare.
    assign w_divShift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_divGe    = (w_divShift >= {1'b0, r_operand});
    assign w_divRem   = w_divGe ? XLEN'(w_divShift - {1'b0, r_operand}) : w_divShift[XLEN-1:0];
    assign w_divNext  = {w_divRem, r_acc[XLEN-2:0], w_divGe};
    assign w_accNext  = r_isDiv ? w_divNext : w_mulNext;
`else
    assign w_accNext  = w_mulNext;
`endif

    assign w_calcResult = r_opHigh ? w_accNext[2*XLEN-1:XLEN] : w_accNext[XLEN-1:0];
    assign w_lastIter   = (r_count == CW'(XLEN-1));
    assign w_accept     = start && !flush && (r_state == S_IDLE);

    always_comb begin
        w_early        = 1'b0;
        w_earlyIllegal = 1'b0;
        w_earlyResult  = '0;
        if (op[1] == 1'b0) begin
            if (FAST_ZERO && ((operand_A == '0) || (operand_B == '0)))
                w_early = 1'b1;
        end else begin
`ifdef MULDIV_DIV_EN
            if (operand_B == '0) begin
                w_early       = 1'b1;
                w_earlyResult = op[0] ? operand_A : '1;
            end
`else
            w_early        = 1'b1;
            w_earlyIllegal = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_result  <= '0;
            r_operand <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            r_opHigh  <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_isDiv   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done    <= 1'b0;
                    r_illegal <= 1'b0;
                    if (w_accept) begin
                        if (w_early) begin
                            r_state   <= S_DONE;
                            r_done    <= 1'b1;
                            r_illegal <= w_earlyIllegal;
                            r_result  <= w_earlyResult;
                        end else begin
                            r_state   <= S_CALC;
                            r_busy    <= 1'b1;
                            r_count   <= '0;
                            r_opHigh  <= op[0];
`ifdef MULDIV_DIV_EN
                            r_isDiv   <= op[1];
`endif
                            r_acc     <= op[1] ? {{XLEN{1'b0}}, operand_A} : {{XLEN{1'b0}}, operand_B};
                            r_operand <= op[1] ? operand_B : operand_A;
                        end
                    end
                end
                S_CALC: begin
                    // A flush drops the op silently; the previous result stays visible.
                    if (flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc   <= w_accNext;
                        r_count <= r_count + 1'b1;
                        if (w_lastIter) begin
                            r_state  <= S_DONE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_result <= w_calcResult;
                        end
                    end
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    r_done    <= 1'b0;
                    r_illegal <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign result     = r_result;
    assign illegal_op = r_illegal;
    assign stall_pipe = (start && (r_state == S_IDLE)) || (r_state == S_CALC);

endmodule

// File: tb/tb_exec_muldiv_seq.sv
// Table-driven scoreboard bench for exec_muldiv_seq; divide vectors depend on MULDIV_DIV_EN.
module tb_exec_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [1:0]  op;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic        busy;
    logic        stallPipe;
    logic        done;
    logic [31:0] result;
    logic        illegalOp;

    exec_muldiv_seq dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .operand_A(operandA), .operand_B(operandB), .flush(flush),
        .busy(busy), .stall_pipe(stallPipe), .done(done),
        .result(result), .illegal_op(illegalOp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        ill;
        int          lat;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          stallSeen = 0;
    logic [31:0] lastResult = 32'h0;

    function automatic vec_t mkVec(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] res, input logic ill, input int lat);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.res = res; v.ill = ill; v.lat = lat;
        return v;
    endfunction

    // Reference model: plain 64-bit arithmetic, independent of the iterative datapath.
    function automatic vec_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] prod;
        vec_t v;
        v = mkVec(o, a, b, 32'h0, 1'b0, 33);
        if (o[1] == 1'b0) begin
            prod  = {32'h0, a} * {32'h0, b};
            v.res = o[0] ? prod[63:32] : prod[31:0];
            if (a == 0 || b == 0) v.lat = 1;
        end else begin
`ifdef MULDIV_DIV_EN
            if (b == 0) begin
                v.res = o[0] ? a : 32'hFFFF_FFFF;
                v.lat = 1;
            end else begin
                v.res = o[0] ? (a % b) : (a / b);
            end
`else
            v.ill = 1'b1;
            v.lat = 1;
`endif
        end
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        @(negedge clk);
        start = 1'b1; op = v.op; operandA = v.a; operandB = v.b;
        #1;
        stallSeen = stallPipe ? 1 : 0;
        e.res = v.res; e.ill = v.ill; e.lat = v.lat;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 2'($urandom);
        operandA = $urandom;
        operandB = $urandom;
    endtask

    // Optionally pulses start mid-operation; those requests must be ignored.
    task automatic checkOutput(input string tag, input bit pulseStart);
        int   cycles;
        int   stalls;
        bit   got;
        exp_t e;
        cycles = 0;
        stalls = stallSeen;
        got = 1'b0;
        while (!got && cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (done) got = 1'b1;
            else if (stallPipe) stalls++;
            if (pulseStart) start = (cycles == 3 || cycles == 10);
        end
        start = 1'b0;
        if (!got) begin
            checks++; failures++;
            $display("[TB] FAIL %s timeout actual=no_done required=done", tag);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            checks++; failures++;
            $display("[TB] FAIL %s unexpected done actual=done required=none", tag);
            return;
        end
        e = sb.pop_front();
        checkVal({tag, " result"}, result, e.res);
        checkVal({tag, " illegal"}, {31'h0, illegalOp}, {31'h0, e.ill});
        checkVal({tag, " latency"}, 32'(cycles), 32'(e.lat));
        checkVal({tag, " stallCycles"}, 32'(stalls), 32'(e.lat));
        checkVal({tag, " stallAtDone"}, {31'h0, stallPipe}, 32'h0);
        lastResult = e.res;
        @(negedge clk);
        checkVal({tag, " donePulse"}, {31'h0, done}, 32'h0);
    endtask

    task automatic noDoneWindow(input string name, input int n);
        int count;
        count = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) count++;
        end
        checkVal(name, 32'(count), 32'h0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; operandA = 32'h0; operandB = 32'h0;
        repeat (2) @(negedge clk);
        checkVal("reset busy", {31'h0, busy}, 32'h0);
        checkVal("reset done", {31'h0, done}, 32'h0);
        checkVal("reset illegal", {31'h0, illegalOp}, 32'h0);
        checkVal("reset result", result, 32'h0);
        checkVal("reset stall", {31'h0, stallPipe}, 32'h0);
        rst = 1'b0;

        vecs.push_back(mkVec(2'b00, 32'd7, 32'd6, 32'd42, 1'b0, 33));
        vecs.push_back(mkVec(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33));
        vecs.push_back(mkVec(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33));
        vecs.push_back(mkVec(2'b00, 32'd3, 32'd0, 32'd0, 1'b0, 1));
        vecs.push_back(mkVec(2'b01, 32'd0, 32'd5, 32'd0, 1'b0, 1));
        vecs.push_back(mkVec(2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b0, 33));
        vecs.push_back(mkVec(2'b01, 32'h0001_0000, 32'h0001_0000, 32'h1, 1'b0, 33));
        vecs.push_back(mkVec(2'b01, 32'hFFFF_FFFF, 32'd2, 32'h1, 1'b0, 33));
`ifdef MULDIV_DIV_EN
        vecs.push_back(mkVec(2'b10, 32'd100, 32'd7, 32'd14, 1'b0, 33));
        vecs.push_back(mkVec(2'b11, 32'd100, 32'd7, 32'd2, 1'b0, 33));
        vecs.push_back(mkVec(2'b10, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1));
        vecs.push_back(mkVec(2'b11, 32'd5, 32'd0, 32'd5, 1'b0, 1));
        vecs.push_back(mkVec(2'b10, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1, 1'b0, 33));
        vecs.push_back(mkVec(2'b11, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 33));
        vecs.push_back(mkVec(2'b10, 32'd3, 32'd5, 32'd0, 1'b0, 33));
`else
        vecs.push_back(mkVec(2'b10, 32'd9, 32'd3, 32'd0, 1'b1, 1));
        vecs.push_back(mkVec(2'b11, 32'd9, 32'd3, 32'd0, 1'b1, 1));
`endif
        for (int i = 0; i < 6; i++)
            vecs.push_back(model(2'($urandom_range(0, 3)), $urandom, $urandom));
        vecs.push_back(mkVec(2'b00, 32'd4, 32'd5, 32'd20, 1'b0, 33));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), 1'b0);
        end

        applyStimulus(mkVec(2'b00, 32'd9, 32'd11, 32'd99, 1'b0, 33));
        checkOutput("ignoredStart", 1'b1);
        noDoneWindow("ignoredStart extraDone", 40);

        // Flush at cycle N+10 of a MUL: idle by N+11, no done, result untouched.
        @(negedge clk);
        start = 1'b1; op = 2'b00; operandA = 32'd7; operandB = 32'd9;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        checkVal("flush busy", {31'h0, busy}, 32'h0);
        checkVal("flush stall", {31'h0, stallPipe}, 32'h0);
        flush = 1'b0;
        noDoneWindow("flush noDone", 40);
        checkVal("flush result", result, lastResult);

        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b00; operandA = 32'd3; operandB = 32'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        checkVal("startFlush busy", {31'h0, busy}, 32'h0);
        noDoneWindow("startFlush noDone", 40);
        checkVal("startFlush result", result, lastResult);

        // Asynchronous reset in the middle of a long operation.
        @(negedge clk);
        start = 1'b1;
`ifdef MULDIV_DIV_EN
        op = 2'b10; operandA = 32'd100; operandB = 32'd7;
`else
        op = 2'b00; operandA = 32'd5; operandB = 32'd5;
`endif
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkVal("midReset busy", {31'h0, busy}, 32'h0);
        checkVal("midReset result", result, 32'h0);
        checkVal("midReset done", {31'h0, done}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        lastResult = 32'h0;
        applyStimulus(mkVec(2'b00, 32'd2, 32'd3, 32'd6, 1'b0, 33));
        checkOutput("afterReset", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
